iob_cache_perf_ctrl: RTL and testbench
======================================

Name: iob_cache_perf_ctrl

Overview:
- Next-generation cache control/status block. It sits between the cache front-end CSR decode and the cache core.
- Provides performance counters with configurable width (including multi-word readout with a coherent snapshot), a selectable wrap or saturate mode, freeze control, counter reset, an invalidate pulse, write-through-buffer status and a version register.
- All six event counters update independently in the same cycle. Simultaneous events are never dropped.

Parameters:
- DATA_W, 32, CSR data width in bits; must be 32.
- CNT_W, 32, counter width in bits; legal range 1..2*DATA_W.
- ADDR_W, 6, CSR byte-address width.
- USE_CTRL_CNT, 1, 1 = counters, freeze and CNT_HI implemented; 0 = those addresses read 0 and ignore writes.
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters hold at all-ones.
- VERSION, 16'h0081, value returned by the VERSION register.

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; when 0, every register holds its value.
- arst_i  in  1  asynchronous active-high reset.
- valid_i  in  1  CSR request.
- addr_i  in  ADDR_W  CSR byte address.
- wdata_i  in  DATA_W  CSR write data.
- wstrb_i  in  DATA_W/8  byte strobes; all zero = read.
- wtbuf_full_i  in  1  write-through buffer full.
- wtbuf_empty_i  in  1  write-through buffer empty.
- read_hit_i, read_miss_i, write_hit_i, write_miss_i  in  1 each  single-cycle event pulses.
- rdata_o  out  DATA_W  read data.
- ready_o  out  1  request acknowledge.
- invalidate_o  out  1  one-cycle invalidate pulse.

Behaviour:
- Reset and clock enable: clk_i single clock, arst_i asynchronous active-high. On reset, every counter, the snapshot, freeze, rdata_o, ready_o and invalidate_o are 0. When cke_i=0 nothing changes, including ready_o.
- Handshake: ready_o is valid_i registered, so it is high exactly one cycle after each valid cycle. Back-to-back requests are accepted every cycle. rdata_o is valid while ready_o=1 and is 0 otherwise.
- Address decode: registers are word-aligned, so word = addr_i[ADDR_W-1:2]. For writes, the effective byte address is word*4 + index of the lowest set wstrb bit.
- Register map (byte addresses):
  - 0x00 WTB_EMPTY (ro).
  - 0x01 WTB_FULL (ro); read at word 0 as bit1, with WTB_EMPTY as bit0.
  - 0x04 RW_HIT, 0x08 RW_MISS, 0x0C READ_HIT, 0x10 READ_MISS, 0x14 WRITE_HIT, 0x18 WRITE_MISS (ro, low DATA_W bits of the counter).
  - 0x1C CNT_HI (ro, snapshot).
  - 0x20 RST_CNTRS (wo).
  - 0x21 INVALIDATE (wo).
  - 0x22 FREEZE (rw, bit0; read at word 0x20 as bit16).
  - 0x24 VERSION (ro).
  - Unmapped reads return 0. Unmapped writes are ignored.
- Snapshot: reading any counter latches counter[CNT_W-1:DATA_W] (zero-extended) into the snapshot in the same cycle. A later CNT_HI read returns the upper half as it was at the low-word read. If CNT_W<=DATA_W, the counter value is zero-extended and the snapshot is always 0.
- Counting: each event increments its own counter by 1.
  - RW_HIT increments by read_hit_i+write_hit_i (0, 1 or 2) in the same cycle.
  - RW_MISS increments by read_miss_i+write_miss_i (0, 1 or 2) in the same cycle.
  - There is no priority between events and no derived or lagging totals.
- Arithmetic: widths are CNT_W+1 internally.
  - Wrap mode: the result is truncated to CNT_W bits.
  - Saturate mode: any carry out clamps the counter to all-ones. An increment of 2 from all-ones minus 1 yields all-ones.
- Freeze: while FREEZE=1, events are ignored and counters stay readable. Writing FREEZE takes effect from the next cycle.
- RST_CNTRS write: clears all counters and the snapshot on the next cycle edge. The clear has priority over any event in that same cycle, and that event is lost. FREEZE is unaffected.
- INVALIDATE write: invalidate_o=1 for exactly one cycle, coincident with ready_o. Consecutive writes give consecutive pulses.
- Reset mid-operation: a pending ready_o or invalidate_o is cleared immediately.

Decomposition:
- Shared package iob_cache_perf_ctrl_pkg: address localparams, reset value of FREEZE, VERSION default.
- One sub-module, iob_cache_perf_cnt: parametrised CNT_W counter with clear, enable, a 2-bit increment input and a SATURATE mode; instantiated six times.
- Byte-offset encoding uses the existing iob_prio_enc (MODE "LOW").

Test Plan:
- Reset, then read 0x24 -> ready_o one cycle later; rdata_o=0x0081. Write 0x21 with wstrb=4'b0010 -> invalidate_o high for exactly 1 cycle.
- Pulse read_hit_i and write_hit_i together for 5 cycles -> READ_HIT=5, WRITE_HIT=5, RW_HIT=10. Then 3 read_miss_i pulses -> READ_MISS=3, RW_MISS=3, READ_HIT still 5.
- CNT_W=40, preload via 2^32+7 events (force) -> read 0x0C returns 7. Then 3 more events, then read 0x1C -> returns 1 (snapshot taken at the low-word read, not live).
- SATURATE=1, CNT_W=4 -> 20 read hits give READ_HIT=15; RW_HIT=15 after simultaneous hit pairs. SATURATE=0 with 17 hits -> READ_HIT=1.
- Write FREEZE=1 (0x22, wstrb=4'b0100, wdata bit16=1) -> 4 events leave counters unchanged. Write RST_CNTRS in the same cycle as a write_miss_i pulse -> all counters 0 afterwards.
- wtbuf_empty_i=1, wtbuf_full_i=0 -> read 0x00 returns 1. Assert arst_i while ready_o=1 -> ready_o and invalidate_o drop to 0 immediately. cke_i=0 during an event -> no count change.

Source files
------------

// File: rtl/iob_cache_perf_ctrl_pkg.sv
// Shared constants for the cache control/status block: CSR byte map, counter count, reset values.
package iob_cache_perf_ctrl_pkg;

  localparam int unsigned ADDR_WTB_EMPTY  = 32'h00;
  localparam int unsigned ADDR_WTB_FULL   = 32'h01;
  localparam int unsigned ADDR_RW_HIT     = 32'h04;
  localparam int unsigned ADDR_RW_MISS    = 32'h08;
  localparam int unsigned ADDR_READ_HIT   = 32'h0C;
  localparam int unsigned ADDR_READ_MISS  = 32'h10;
  localparam int unsigned ADDR_WRITE_HIT  = 32'h14;
  localparam int unsigned ADDR_WRITE_MISS = 32'h18;
  localparam int unsigned ADDR_CNT_HI     = 32'h1C;
  localparam int unsigned ADDR_RST_CNTRS  = 32'h20;
  localparam int unsigned ADDR_INVALIDATE = 32'h21;
  localparam int unsigned ADDR_FREEZE     = 32'h22;
  localparam int unsigned ADDR_VERSION    = 32'h24;

  // Counters sit at consecutive words starting at RW_HIT, in this order.
  localparam int N_CNT      = 6;
  localparam int CNT_RW_HIT = 0;
  localparam int FREEZE_BIT = 16;

  localparam logic        FREEZE_RST  = 1'b0;
  localparam logic [15:0] VERSION_DEF = 16'h0081;

endpackage

// File: rtl/iob_cache_perf_cnt.sv
// Event counter with clear, enable and 0..2 increment; one-cycle update, wraps or saturates.
module iob_cache_perf_cnt #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             cke,
  input  logic             arst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   sum;

  // One spare bit so the carry out of an increment of 2 is never lost.
  assign sum = {1'b0, cnt_q} + (CNT_W + 1)'(inc);
  assign cnt = cnt_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (cke) begin
      if (clr) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= (SATURATE != 0 && sum[CNT_W]) ? '1 : sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/iob_prio_enc.sv
// Priority encoder: index of the lowest ("LOW") or highest set bit; combinational, 0 when none set.
module iob_prio_enc #(
  parameter int W    = 4,
  parameter     MODE = "LOW"
) (
  input  logic [W-1:0]         unencoded,
  output logic [$clog2(W)-1:0] encoded
);

  localparam int EW = $clog2(W);

  always_comb begin
    encoded = '0;
    if (MODE == "LOW") begin
      for (int i = W - 1; i >= 0; i--) begin
        if (unencoded[i]) encoded = EW'(i);
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (unencoded[i]) encoded = EW'(i);
      end
    end
  end

endmodule

// File: rtl/iob_cache_perf_ctrl.sv
// Cache CSR block: six event counters, snapshot, freeze, invalidate, status and version.
// Responds one cycle after each request (ready = registered valid); accepts a request every cycle.
module iob_cache_perf_ctrl
  import iob_cache_perf_ctrl_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter int          CNT_W        = 32,
  parameter int          ADDR_W       = 6,
  parameter int          USE_CTRL_CNT = 1,
  parameter int          SATURATE     = 0,
  parameter logic [15:0] VERSION      = VERSION_DEF
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wtbuf_full_i,
  input  logic                wtbuf_empty_i,
  input  logic                read_hit_i,
  input  logic                read_miss_i,
  input  logic                write_hit_i,
  input  logic                write_miss_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                invalidate_o
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int LANE_W  = $clog2(STRB_W);
  localparam int WORD_W  = ADDR_W - 2;
  localparam int EXT_W   = 2 * DATA_W;
  localparam bit CTRL_EN = (USE_CTRL_CNT != 0);

  logic [WORD_W-1:0] word;
  logic [LANE_W-1:0] lane;
  logic [ADDR_W-1:0] waddr;
  logic              rd_req;
  logic              wr_req;
  logic              do_rst;
  logic              do_inv;
  logic              do_frz;
  logic              freeze_q;
  logic              cnt_en;
  logic              snap_ld;
  logic [DATA_W-1:0] snap_q;
  logic [DATA_W-1:0] snap_nxt;
  logic [DATA_W-1:0] rd_val;
  logic [1:0]        inc     [N_CNT];
  logic [CNT_W-1:0]  cnt     [N_CNT];
  logic [EXT_W-1:0]  cnt_ext [N_CNT];
  logic              unused_bits;

  assign word   = addr_i[ADDR_W-1:2];
  assign wr_req = valid_i & (|wstrb_i);
  assign rd_req = valid_i & ~(|wstrb_i);

  iob_prio_enc #(
    .W    (STRB_W),
    .MODE ("LOW")
  ) u_lane (
    .unencoded (wstrb_i),
    .encoded   (lane)
  );

  // Writes decode on the byte selected by the lowest strobe, not on addr_i[1:0].
  assign waddr  = {word, lane};
  assign do_rst = CTRL_EN && wr_req && (waddr == ADDR_W'(ADDR_RST_CNTRS));
  assign do_inv = wr_req && (waddr == ADDR_W'(ADDR_INVALIDATE));
  assign do_frz = CTRL_EN && wr_req && (waddr == ADDR_W'(ADDR_FREEZE));
  assign cnt_en = CTRL_EN && !freeze_q;

  assign inc[0] = {1'b0, read_hit_i}  + {1'b0, write_hit_i};
  assign inc[1] = {1'b0, read_miss_i} + {1'b0, write_miss_i};
  assign inc[2] = {1'b0, read_hit_i};
  assign inc[3] = {1'b0, read_miss_i};
  assign inc[4] = {1'b0, write_hit_i};
  assign inc[5] = {1'b0, write_miss_i};

  for (genvar k = 0; k < N_CNT; k++) begin : g_cnt
    iob_cache_perf_cnt #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk  (clk_i),
      .cke  (cke_i),
      .arst (arst_i),
      .clr  (do_rst),
      .en   (cnt_en),
      .inc  (inc[k]),
      .cnt  (cnt[k])
    );
  end

  always_comb begin
    for (int k = 0; k < N_CNT; k++) cnt_ext[k] = EXT_W'(cnt[k]);
  end

  always_comb begin
    rd_val   = '0;
    snap_ld  = 1'b0;
    snap_nxt = '0;
    if (word == '0) rd_val = DATA_W'({wtbuf_full_i, wtbuf_empty_i});
    for (int k = 0; k < N_CNT; k++) begin
      if (CTRL_EN && word == WORD_W'(k + CNT_RW_HIT + 1)) begin
        rd_val   = cnt_ext[k][DATA_W-1:0];
        snap_ld  = 1'b1;
        snap_nxt = cnt_ext[k][EXT_W-1:DATA_W];
      end
    end
    if (CTRL_EN && word == WORD_W'(ADDR_CNT_HI >> 2)) rd_val = snap_q;
    if (CTRL_EN && word == WORD_W'(ADDR_FREEZE >> 2)) rd_val[FREEZE_BIT] = freeze_q;
    if (word == WORD_W'(ADDR_VERSION >> 2)) rd_val = DATA_W'(VERSION);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ready_o      <= 1'b0;
      rdata_o      <= '0;
      invalidate_o <= 1'b0;
      freeze_q     <= FREEZE_RST;
      snap_q       <= '0;
    end else if (cke_i) begin
      ready_o      <= valid_i;
      rdata_o      <= rd_req ? rd_val : '0;
      invalidate_o <= do_inv;
      if (do_frz) freeze_q <= wdata_i[FREEZE_BIT];
      if (do_rst) begin
        snap_q <= '0;
      end else if (rd_req && snap_ld) begin
        snap_q <= snap_nxt;
      end
    end
  end

  assign unused_bits = ^{addr_i[1:0], wdata_i};

endmodule

// File: tb/tb_iob_cache_perf_ctrl.sv
// Scoreboard bench: three DUT configurations share one stimulus stream and are checked against an arithmetic model.
module tb_iob_cache_perf_ctrl;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        arst = 1'b1;
  logic        valid = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wtbuf_full = 1'b0;
  logic        wtbuf_empty = 1'b0;
  logic        rh = 1'b0, rm = 1'b0, wh = 1'b0, wm = 1'b0;

  logic [31:0] rdata [3];
  logic        ready [3];
  logic        inval [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_cache_perf_ctrl #(.CNT_W(40), .SATURATE(0)) u_dut0 (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .valid_i(valid), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .wtbuf_full_i(wtbuf_full), .wtbuf_empty_i(wtbuf_empty),
    .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
    .rdata_o(rdata[0]), .ready_o(ready[0]), .invalidate_o(inval[0]));

  iob_cache_perf_ctrl #(.CNT_W(4), .SATURATE(1)) u_dut1 (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .valid_i(valid), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .wtbuf_full_i(wtbuf_full), .wtbuf_empty_i(wtbuf_empty),
    .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
    .rdata_o(rdata[1]), .ready_o(ready[1]), .invalidate_o(inval[1]));

  iob_cache_perf_ctrl #(.CNT_W(4), .SATURATE(0)) u_dut2 (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .valid_i(valid), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .wtbuf_full_i(wtbuf_full), .wtbuf_empty_i(wtbuf_empty),
    .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
    .rdata_o(rdata[2]), .ready_o(ready[2]), .invalidate_o(inval[2]));

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] rd;
    logic        inv;
  } resp_t;

  resp_t           sb [3][$];
  longint unsigned mcnt [3][6];
  longint unsigned msnap [3];
  bit              mfrz;
  int              cw [3] = '{40, 4, 4};
  bit              csat [3] = '{1'b0, 1'b1, 1'b0};

  function automatic longint unsigned add_ev(longint unsigned c, int n, int w, bit sat);
    longint unsigned mx;
    longint unsigned s;
    mx = (64'd1 << w) - 64'd1;
    s  = c + 64'(n);
    if (s > mx) return sat ? mx : (s & mx);
    return s;
  endfunction

  function automatic logic [31:0] exp_read(int d, int a);
    int w;
    longint unsigned v;
    w = a >> 2;
    if (w == 0) return {30'd0, wtbuf_full, wtbuf_empty};
    if (w >= 1 && w <= 6) begin
      v = mcnt[d][w-1];
      return v[31:0];
    end
    if (w == 7) begin
      v = msnap[d];
      return v[31:0];
    end
    if (w == 8) return mfrz ? 32'h0001_0000 : 32'h0;
    if (w == 9) return 32'h0000_0081;
    return 32'h0;
  endfunction

  function automatic void chk(string nm, int d, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h exp=%0h", nm, d, got, exp);
    end
  endfunction

  int    iv [6];
  int    lo;
  int    eff;
  bit    m_clr, m_inv, m_fwr, m_fval;
  resp_t r_new;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 6; k++) mcnt[d][k] = 0;
        msnap[d] = 0;
        sb[d].delete();
      end
      mfrz = 1'b0;
    end else if (cke) begin
      m_clr = 1'b0; m_inv = 1'b0; m_fwr = 1'b0; m_fval = 1'b0;
      iv[0] = int'(rh) + int'(wh);
      iv[1] = int'(rm) + int'(wm);
      iv[2] = int'(rh);
      iv[3] = int'(rm);
      iv[4] = int'(wh);
      iv[5] = int'(wm);
      if (valid) begin
        if (wstrb == 4'd0) begin
          for (int d = 0; d < 3; d++) begin
            r_new.rd  = exp_read(d, int'(addr));
            r_new.inv = 1'b0;
            sb[d].push_back(r_new);
            if ((addr >> 2) >= 1 && (addr >> 2) <= 6) msnap[d] = mcnt[d][(addr >> 2) - 1] >> 32;
          end
        end else begin
          lo = 0;
          for (int i = 3; i >= 0; i--) if (wstrb[i]) lo = i;
          eff = (int'(addr) / 4) * 4 + lo;
          m_clr = (eff == 'h20);
          m_inv = (eff == 'h21);
          if (eff == 'h22) begin
            m_fwr  = 1'b1;
            m_fval = wdata[16];
          end
          for (int d = 0; d < 3; d++) begin
            r_new.rd  = 32'h0;
            r_new.inv = m_inv;
            sb[d].push_back(r_new);
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 6; k++) begin
          if (m_clr) mcnt[d][k] = 0;
          else if (!mfrz) mcnt[d][k] = add_ev(mcnt[d][k], iv[k], cw[d], csat[d]);
        end
        if (m_clr) msnap[d] = 0;
      end
      if (m_fwr) mfrz = m_fval;
    end
  end

  // ---------------- monitor ----------------
  resp_t r_got;
  always @(negedge clk) begin
    if (!arst) begin
      for (int d = 0; d < 3; d++) begin
        if (ready[d]) begin
          if (sb[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready dut%0d got=1 exp=0", d);
          end else begin
            r_got = sb[d].pop_front();
            chk("rdata", d, 64'(rdata[d]), 64'(r_got.rd));
            chk("invalidate", d, 64'(inval[d]), 64'(r_got.inv));
          end
        end else begin
          chk("idle_rdata", d, 64'(rdata[d]), 64'h0);
          chk("idle_invalidate", d, 64'(inval[d]), 64'h0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [5:0] a, input logic [3:0] s, input logic [31:0] dat);
    valid = 1'b1; addr = a; wstrb = s; wdata = dat;
    tick();
    valid = 1'b0; wstrb = 4'd0; wdata = '0;
  endtask

  task automatic rd(input logic [5:0] a);
    req(a, 4'd0, 32'h0);
  endtask

  task automatic ev(input logic h_r, input logic m_r, input logic h_w, input logic m_w, input int n);
    for (int i = 0; i < n; i++) begin
      rh = h_r; rm = m_r; wh = h_w; wm = m_w;
      tick();
    end
    rh = 1'b0; rm = 1'b0; wh = 1'b0; wm = 1'b0;
  endtask

  bit prev_v;

  initial begin
    #1;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", d, 64'(ready[d]), 64'h0);
      chk("rst_rdata", d, 64'(rdata[d]), 64'h0);
      chk("rst_invalidate", d, 64'(inval[d]), 64'h0);
    end
    arst = 1'b0;
    tick();

    rd(6'h24);
    rd(6'h04);
    req(6'h21, 4'b0010, 32'h0);
    tick();

    ev(1, 0, 1, 0, 5);
    rd(6'h04); rd(6'h0C); rd(6'h14);
    ev(0, 1, 0, 0, 3);
    rd(6'h08); rd(6'h10); rd(6'h0C);

    // Preload READ_HIT of the 40-bit instance just above 2^32.
    tick();
    force u_dut0.g_cnt[2].u_cnt.cnt_q = 40'h01_0000_0007;
    mcnt[0][2] = 64'h1_0000_0007;
    tick();
    release u_dut0.g_cnt[2].u_cnt.cnt_q;
    rd(6'h0C);
    ev(1, 0, 0, 0, 3);
    rd(6'h1C);
    rd(6'h0C);

    req(6'h20, 4'b0001, 32'h0);
    ev(1, 0, 0, 0, 17);
    rd(6'h0C);
    ev(1, 0, 1, 0, 3);
    rd(6'h04); rd(6'h0C);

    req(6'h22, 4'b0100, 32'h0001_0000);
    rd(6'h20);
    ev(1, 1, 1, 1, 4);
    rd(6'h04); rd(6'h18); rd(6'h0C);
    req(6'h22, 4'b0100, 32'h0);

    ev(0, 0, 1, 1, 2);
    wm = 1'b1;
    req(6'h20, 4'b0001, 32'h0);
    wm = 1'b0;
    for (int a = 4; a <= 'h1C; a += 4) rd(6'(a));

    wtbuf_empty = 1'b1; wtbuf_full = 1'b0;
    rd(6'h00);
    wtbuf_empty = 1'b0; wtbuf_full = 1'b1;
    rd(6'h01);
    rd(6'h3C);
    req(6'h04, 4'hF, 32'hFFFF_FFFF);
    req(6'h24, 4'hF, 32'h0);
    rd(6'h24);

    tick();
    cke = 1'b0; rh = 1'b1;
    valid = 1'b1; addr = 6'h0C;
    tick();
    cke = 1'b1; rh = 1'b0; valid = 1'b0;
    rd(6'h0C);

    prev_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      cke = (!prev_v && $urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      rh = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      wh = 1'($urandom_range(0, 1));
      wm = 1'($urandom_range(0, 1));
      wtbuf_full  = 1'($urandom_range(0, 1));
      wtbuf_empty = 1'($urandom_range(0, 1));
      valid = 1'($urandom_range(0, 1));
      addr  = 6'($urandom_range(0, 63));
      wstrb = ($urandom_range(0, 9) < 7) ? 4'd0 : 4'($urandom_range(1, 15));
      wdata = $urandom;
      prev_v = valid;
      tick();
    end
    cke = 1'b1; valid = 1'b0; wstrb = 4'd0;
    rh = 1'b0; rm = 1'b0; wh = 1'b0; wm = 1'b0;
    tick();
    for (int a = 0; a <= 'h24; a += 4) rd(6'(a));
    tick();

    req(6'h21, 4'b0010, 32'h0);
    chk("ready_before_arst", 0, 64'(ready[0]), 64'h1);
    chk("inv_before_arst", 0, 64'(inval[0]), 64'h1);
    arst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("arst_ready", d, 64'(ready[d]), 64'h0);
      chk("arst_invalidate", d, 64'(inval[d]), 64'h0);
    end
    tick();
    arst = 1'b0;
    tick();
    rd(6'h04); rd(6'h20);
    tick(); tick();
    for (int d = 0; d < 3; d++) chk("sb_drained", d, 64'(sb[d].size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
